// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI boot-ROM read path.
package qspi_pkg;
    localparam logic [7:0] QSPI_CMD_READ_QO = 8'h6B;
    localparam int         FLASH_AW         = 24;
    localparam logic       PORT0            = 1'b0;
    localparam logic       PORT1            = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        HOLD,
        CSHI
    } qspi_state_e;
endpackage

// File: rtl/qspi_phy_shift.sv
// SCLK phase generator and 32-bit shifter for the QSPI pads.
// Serial-out mode shifts MSB first on IO0; quad mode shifts io_di in.
module qspi_phy_shift
    import qspi_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        start_ph,
    input  logic        quad,
    input  logic [5:0]  nbits,
    input  logic [31:0] din,
    input  logic [3:0]  io_di,
    output logic        sclk,
    output logic        io0,
    output logic        last,
    output logic [7:0]  rx_byte
);
    logic        busy_q, busy_d;
    logic        ph_q, ph_d;
    logic        quad_q, quad_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] sh_q, sh_d;

    assign sclk    = ph_q;
    assign io0     = sh_q[31];
    assign last    = busy_q & ph_q & (cnt_q == 6'd1);
    assign rx_byte = {sh_q[3:0], io_di};

    // A start in the same cycle as last chains segments with no SCLK gap.
    always_comb begin
        busy_d = busy_q;
        ph_d   = ph_q;
        quad_d = quad_q;
        cnt_d  = cnt_q;
        sh_d   = sh_q;
        if (start) begin
            busy_d = 1'b1;
            ph_d   = start_ph;
            quad_d = quad;
            cnt_d  = nbits;
            sh_d   = din;
        end else if (busy_q) begin
            ph_d = ~ph_q;
            if (ph_q) begin
                cnt_d = cnt_q - 6'd1;
                sh_d  = quad_q ? {sh_q[27:0], io_di} : {sh_q[30:0], 1'b0};
                if (cnt_q == 6'd1) begin
                    busy_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            ph_q   <= 1'b0;
            quad_q <= 1'b0;
            cnt_q  <= '0;
            sh_q   <= '0;
        end else begin
            busy_q <= busy_d;
            ph_q   <= ph_d;
            quad_q <= quad_d;
            cnt_q  <= cnt_d;
            sh_q   <= sh_d;
        end
    end
endmodule

// File: rtl/qspi_rom_arbiter.sv
// Two-port read arbiter for a W25Q QSPI flash using Quad Output Fast Read,
// with CS# held low between bytes for sequential streaming.
module qspi_rom_arbiter
    import qspi_pkg::*;
#(
    parameter int DUMMY_SCLK   = 8,
    parameter int HOLD_TIMEOUT = 15,
    parameter int CS_HIGH_MIN  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    input  logic [FLASH_AW-1:0] req0_addr,
    output logic                req0_done,
    input  logic                req1_valid,
    input  logic [FLASH_AW-1:0] req1_addr,
    output logic                req1_done,
    output logic [7:0]          rdata,
    output logic                cs_n,
    output logic                sclk,
    output logic [3:0]          io_do,
    output logic [3:0]          io_oe,
    input  logic [3:0]          io_di
);
    localparam int CW = $clog2(HOLD_TIMEOUT + CS_HIGH_MIN + 1);

    qspi_state_e         state_q, state_d;
    logic                gnt_q, gnt_d;
    logic [FLASH_AW-1:0] addr_q, addr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                done0_q, done0_d;
    logic                done1_q, done1_d;
    logic [7:0]          rdata_q, rdata_d;

    logic                phy_start, phy_ph, phy_quad, phy_io0, phy_last;
    logic [5:0]          phy_nbits;
    logic [31:0]         phy_din;
    logic [7:0]          phy_rx;

    logic                win_valid, win_port, shift_out;
    logic [FLASH_AW-1:0] win_addr, next_addr;

    assign win_valid = req0_valid | req1_valid;
    assign win_port  = req0_valid ? PORT0 : PORT1;
    assign win_addr  = req0_valid ? req0_addr : req1_addr;
    assign next_addr = addr_q + 24'd1;

    assign shift_out = (state_q == CMD) || (state_q == ADDR);
    assign cs_n      = (state_q == IDLE) || (state_q == CSHI);
    assign io_oe     = {3'b000, shift_out};
    assign io_do     = {3'b000, shift_out & phy_io0};
    assign req0_done = done0_q;
    assign req1_done = done1_q;
    assign rdata     = rdata_q;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        rdata_d   = rdata_q;
        phy_start = 1'b0;
        phy_ph    = 1'b0;
        phy_quad  = 1'b0;
        phy_nbits = 6'd2;
        phy_din   = '0;
        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    gnt_d     = win_port;
                    addr_d    = win_addr;
                    state_d   = CMD;
                    phy_start = 1'b1;
                    phy_nbits = 6'd8;
                    phy_din   = {QSPI_CMD_READ_QO, 24'h0};
                end
            end
            CMD: begin
                if (phy_last) begin
                    state_d   = ADDR;
                    phy_start = 1'b1;
                    phy_nbits = 6'd24;
                    phy_din   = {addr_q, 8'h00};
                end
            end
            ADDR: begin
                if (phy_last) begin
                    phy_start = 1'b1;
                    if (DUMMY_SCLK == 0) begin
                        state_d  = DATA;
                        phy_quad = 1'b1;
                    end else begin
                        state_d   = DUMMY;
                        phy_nbits = 6'(DUMMY_SCLK);
                    end
                end
            end
            DUMMY: begin
                if (phy_last) begin
                    state_d   = DATA;
                    phy_start = 1'b1;
                    phy_quad  = 1'b1;
                end
            end
            DATA: begin
                if (phy_last) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    rdata_d = phy_rx;
                    done0_d = (gnt_q == PORT0);
                    done1_d = (gnt_q == PORT1);
                end
            end
            HOLD: begin
                // The flash already drove the next high nibble, so resume on a high SCLK phase.
                if (win_valid && (win_addr == next_addr)) begin
                    gnt_d     = win_port;
                    addr_d    = win_addr;
                    state_d   = DATA;
                    phy_start = 1'b1;
                    phy_ph    = 1'b1;
                    phy_quad  = 1'b1;
                end else if (win_valid || (cnt_q == CW'(HOLD_TIMEOUT - 1))) begin
                    state_d = CSHI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CSHI: begin
                if (cnt_q == CW'(CS_HIGH_MIN - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= PORT0;
            addr_q  <= '0;
            cnt_q   <= '0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            rdata_q <= rdata_d;
        end
    end

    qspi_phy_shift u_phy (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (phy_start),
        .start_ph (phy_ph),
        .quad     (phy_quad),
        .nbits    (phy_nbits),
        .din      (phy_din),
        .io_di    (io_di),
        .sclk     (sclk),
        .io0      (phy_io0),
        .last     (phy_last),
        .rx_byte  (phy_rx)
    );
endmodule

// File: tb/tb_qspi_rom_arbiter.sv
// Directed bench for qspi_rom_arbiter with a behavioural W25Q quad-read flash.
module tb_qspi_rom_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [23:0] req0_addr, req1_addr;
    logic        req0_done, req1_done;
    logic [7:0]  rdata;
    logic        cs_n, sclk;
    logic [3:0]  io_do, io_oe, io_di, pad;

    logic        fl_oe = 1'b0;
    logic [3:0]  fl_drv = 4'h0;
    logic [7:0]  opc = 8'h00;
    logic [23:0] fadr = 24'h0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_done0 = 0, n_done1 = 0, n_both = 0;
    int cs_fall = 0, hi_cnt = 0, last_hi = 0;
    logic cs_prev = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_pad
        assign pad[g] = io_oe[g] ? io_do[g] : (fl_oe ? fl_drv[g] : 1'b1);
    end
    assign io_di = pad;

    qspi_rom_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_done  (req0_done),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_done  (req1_done),
        .rdata      (rdata),
        .cs_n       (cs_n),
        .sclk       (sclk),
        .io_do      (io_do),
        .io_oe      (io_oe),
        .io_di      (io_di)
    );

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        if (a == 24'h000010) return 8'hA5;
        if (a == 24'hFFFFFF) return 8'hC3;
        return a[23:16] ^ a[15:8] ^ a[7:0] ^ 8'h5A;
    endfunction

    // Flash: opcode/address on rising SCLK, data nibbles after each falling SCLK.
    int          fn = 0;
    always @(posedge sclk or negedge sclk or posedge cs_n) begin
        int          j;
        logic [7:0]  b;
        logic [23:0] a;
        if (cs_n === 1'b1) begin
            fn    = 0;
            fl_oe = 1'b0;
        end else if (sclk === 1'b1) begin
            fn++;
            if (fn <= 8) opc = {opc[6:0], pad[0]};
            else if (fn <= 32) fadr = {fadr[22:0], pad[0]};
        end else if (fn >= 40) begin
            j      = fn - 40;
            a      = fadr + 24'(j / 2);
            b      = flash_byte(a);
            fl_drv = (j % 2 == 1) ? b[3:0] : b[7:4];
            fl_oe  = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (req0_done === 1'b1) n_done0++;
        if (req1_done === 1'b1) n_done1++;
        if (req0_done === 1'b1 && req1_done === 1'b1) n_both++;
        if (cs_prev === 1'b1 && cs_n === 1'b0) cs_fall++;
        cs_prev = cs_n;
        if (cs_n === 1'b1) begin
            hi_cnt++;
        end else begin
            if (hi_cnt != 0) last_hi = hi_cnt;
            hi_cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int max, output int at);
        at = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (req0_done === 1'b1 || req1_done === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, at, prev, f0, d0;
        logic [7:0] exp_s [4];
        exp_s[0] = 8'h5B;
        exp_s[1] = 8'h5A;
        exp_s[2] = 8'h59;
        exp_s[3] = 8'h58;

        rst_n = 1'b0;
        req0_valid = 1'b0; req0_addr = '0;
        req1_valid = 1'b0; req1_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_io_oe", io_oe, 4'h0);
        chk("rst_io_do", io_do, 4'h0);
        chk("rst_done", {req0_done, req1_done}, 2'b00);
        chk("rst_rdata", rdata, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single read
        c0 = cyc;
        req0_valid = 1'b1; req0_addr = 24'h000010;
        @(negedge clk);
        chk("single_cs_low", cs_n, 0);
        chk("single_io_oe", io_oe, 4'b0001);
        wait_done(200, at);
        chk("single_lat", at, c0 + 85);
        chk("single_port", {req0_done, req1_done}, 2'b10);
        chk("single_rdata", rdata, 8'hA5);
        req0_valid = 1'b0;
        chk("single_opcode", opc, 8'h6B);
        chk("single_addr", fadr, 24'h000010);
        repeat (20) @(negedge clk);

        // Sequential streaming
        f0 = cs_fall;
        c0 = cyc;
        req0_valid = 1'b1; req0_addr = 24'h000100;
        wait_done(200, at);
        chk("stream0_lat", at, c0 + 85);
        chk("stream0_rdata", rdata, exp_s[0]);
        for (int k = 1; k < 4; k++) begin
            prev = at;
            req0_addr = 24'h000100 + 24'(k);
            wait_done(20, at);
            chk("stream_gap", at - prev, 4);
            chk("stream_rdata", rdata, exp_s[k]);
        end
        req0_valid = 1'b0;
        chk("stream_cs_windows", cs_fall - f0, 1);
        repeat (20) @(negedge clk);

        // Contention
        c0 = cyc;
        req0_valid = 1'b1; req0_addr = 24'h000020;
        req1_valid = 1'b1; req1_addr = 24'h000040;
        wait_done(200, at);
        chk("cont0_lat", at, c0 + 85);
        chk("cont0_port", {req0_done, req1_done}, 2'b10);
        chk("cont0_rdata", rdata, 8'h7A);
        req0_valid = 1'b0;
        prev = at;
        wait_done(200, at);
        chk("cont1_gap", at - prev, 88);
        chk("cont1_port", {req0_done, req1_done}, 2'b01);
        chk("cont1_rdata", rdata, 8'h1A);
        req1_valid = 1'b0;
        chk("cont_cs_high", last_hi >= 2, 1);
        repeat (20) @(negedge clk);

        // HOLD timeout
        c0 = cyc;
        req0_valid = 1'b1; req0_addr = 24'h000050;
        wait_done(200, at);
        chk("to_first_lat", at, c0 + 85);
        chk("to_first_rdata", rdata, 8'h0A);
        req0_valid = 1'b0;
        repeat (14) @(negedge clk);
        chk("to_cs_still_low", cs_n, 0);
        @(negedge clk);
        chk("to_cs_rise", cs_n, 1);
        repeat (5) @(negedge clk);
        c0 = cyc;
        req0_valid = 1'b1; req0_addr = 24'h000051;
        wait_done(200, at);
        chk("to_full_lat", at, c0 + 85);
        chk("to_rdata", rdata, 8'h0B);
        req0_valid = 1'b0;
        repeat (20) @(negedge clk);

        // Address wrap streaming
        c0 = cyc;
        req0_valid = 1'b1; req0_addr = 24'hFFFFFF;
        wait_done(200, at);
        chk("wrap_lat", at, c0 + 85);
        chk("wrap_top_rdata", rdata, 8'hC3);
        prev = at;
        req0_addr = 24'h000000;
        wait_done(20, at);
        chk("wrap_gap", at - prev, 4);
        chk("wrap_zero_rdata", rdata, 8'h5A);
        req0_valid = 1'b0;
        repeat (20) @(negedge clk);

        // Reset in the middle of the address phase
        d0 = n_done0 + n_done1;
        c0 = cyc;
        req1_valid = 1'b1; req1_addr = 24'h000030;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("midrst_cs_n", cs_n, 1);
        chk("midrst_io_oe", io_oe, 4'h0);
        chk("midrst_sclk", sclk, 0);
        chk("midrst_rdata", rdata, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst_no_done", n_done0 + n_done1 - d0, 0);
        c0 = cyc;
        req1_valid = 1'b1;
        wait_done(200, at);
        chk("midrst_next_lat", at, c0 + 85);
        chk("midrst_next_port", {req0_done, req1_done}, 2'b01);
        chk("midrst_next_rdata", rdata, 8'h6A);
        req1_valid = 1'b0;
        repeat (5) @(negedge clk);

        chk("done0_count", n_done0, 10);
        chk("done1_count", n_done1, 2);
        chk("both_done", n_both, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
